// File: rtl/ram_arb_pkg.sv
// Shared definitions for the SPI RAM command arbiter: RAM command opcodes
// and the arbiter FSM state encoding.
package ram_arb_pkg;

    localparam logic [1:0] OP_WADDR = 2'b00;
    localparam logic [1:0] OP_WDATA = 2'b01;
    localparam logic [1:0] OP_RADDR = 2'b10;
    localparam logic [1:0] OP_RDATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR0 = 3'd1,
        ST_ADDR1 = 3'd2,
        ST_DATA  = 3'd3,
        ST_RWAIT = 3'd4,
        ST_ACK   = 3'd5
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from req and the
// last granted port; last_gnt only moves when the owner accepts the grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_gnt_q, last_gnt_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (advance && (gnt != 2'b00)) last_gnt_d = gnt[1];
    end

    // Reset to port 1 so port 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_gnt_q <= 1'b1;
        else          last_gnt_q <= last_gnt_d;
    end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Shares the single-port SPI RAM between two requesters and turns each granted
// transaction into the RAM's 10-bit command-word sequence. All outputs registered.
module ram_cmd_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [9:0]        ram_din,
    output logic              ram_rx_valid,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic              ram_tx_valid,
    output arb_state_e        state_dbg
);

    arb_state_e        state_q, state_d;
    logic [1:0]        gnt;
    logic              grant_ok;
    logic              we_q, we_d, port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d, busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [9:0]        ram_din_q, ram_din_d;
    logic              ram_rx_valid_q, ram_rx_valid_d;

    // IDLE never grants while the RAM's tx_valid window is open.
    assign grant_ok = (state_q == ST_IDLE) && !ram_tx_valid && (gnt != 2'b00);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({req1, req0}),
        .advance (grant_ok),
        .gnt     (gnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_ok) state_d = ST_ADDR0;
            ST_ADDR0: state_d = ST_ADDR1;
            ST_ADDR1: state_d = ST_DATA;
            ST_DATA:  state_d = we_q ? ST_ACK : ST_RWAIT;
            ST_RWAIT: if (ram_tx_valid || (cnt_q == 8'(TIMEOUT_CYCLES - 1))) state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with it after the edge.
    always_comb begin
        port_d  = grant_ok ? gnt[1] : port_q;
        we_d    = grant_ok ? (gnt[1] ? we1 : we0) : we_q;
        addr_d  = grant_ok ? (gnt[1] ? addr1 : addr0) : addr_q;
        wdata_d = grant_ok ? (gnt[1] ? wdata1 : wdata0) : wdata_q;
        cnt_d   = (state_q == ST_RWAIT) ? cnt_q + 8'd1 : 8'd0;

        ram_rx_valid_d = 1'b0;
        ram_din_d      = 10'h000;
        case (state_d)
            ST_ADDR0, ST_ADDR1: begin
                ram_rx_valid_d = 1'b1;
                ram_din_d      = {(we_d ? OP_WADDR : OP_RADDR), addr_d};
            end
            ST_DATA: begin
                ram_rx_valid_d = 1'b1;
                ram_din_d      = we_d ? {OP_WDATA, wdata_d} : {OP_RDATA, 8'h00};
            end
            default: ;
        endcase

        ack0_d  = (state_d == ST_ACK) && !port_d;
        ack1_d  = (state_d == ST_ACK) && port_d;
        busy_d  = (state_d != ST_IDLE);
        err_d   = 1'b0;
        rdata_d = rdata_q;
        if ((state_q == ST_RWAIT) && (state_d == ST_ACK)) begin
            err_d   = !ram_tx_valid;
            rdata_d = ram_tx_valid ? ram_dout : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_q         <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            cnt_q          <= 8'd0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            rdata_q        <= '0;
            ram_din_q      <= 10'h000;
            ram_rx_valid_q <= 1'b0;
        end else begin
            port_q         <= port_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            cnt_q          <= cnt_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
            rdata_q        <= rdata_d;
            ram_din_q      <= ram_din_d;
            ram_rx_valid_q <= ram_rx_valid_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign rdata        = rdata_q;
    assign ram_din      = ram_din_q;
    assign ram_rx_valid = ram_rx_valid_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Bench for ram_cmd_arbiter: a behavioural SPI RAM stand-in plus directed and
// randomized transactions checked against a reference memory and timing rules.
module tb_ram_cmd_arbiter;
    import ram_arb_pkg::*;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, err, busy, ram_rx_valid;
    logic [7:0] rdata;
    logic [9:0] ram_din;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    arb_state_e state_dbg;

    int tests_run = 0, tests_failed = 0;

    // Reference model: what each address should hold; expected read data queue.
    logic [7:0] ref_mem [256];
    logic [7:0] exp_q[$];
    logic [9:0] mon_q[$];
    int         overlap_cnt = 0, din_idle_bad = 0;

    // RAM stand-in controls.
    int         tx_window = 3;
    bit         stub_mode = 1'b0;
    logic [7:0] ram_mem [256];
    logic [7:0] ram_addr;
    int         ram_wcnt, ram_txcnt;

    always #5 clk = ~clk;

    ram_cmd_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid),
        .state_dbg(state_dbg)
    );

    // RAM: word 0 idle decode, word 1 address capture, word 2 data/read command.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_wcnt <= 0; ram_txcnt <= 0; ram_tx_valid <= 1'b0; ram_dout <= '0;
        end else begin
            if (ram_txcnt != 0) begin
                ram_txcnt <= ram_txcnt - 1;
                if (ram_txcnt == 1) ram_tx_valid <= 1'b0;
            end
            if (ram_rx_valid) begin
                if (ram_wcnt == 1) ram_addr <= ram_din[7:0];
                if (ram_wcnt == 2) begin
                    ram_wcnt <= 0;
                    if (ram_din[9:8] == 2'b01) ram_mem[ram_addr] <= ram_din[7:0];
                    else if (ram_din[9:8] == 2'b11 && !stub_mode) begin
                        ram_dout <= ram_mem[ram_addr]; ram_tx_valid <= 1'b1; ram_txcnt <= tx_window;
                    end
                end else ram_wcnt <= ram_wcnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (ram_rx_valid) mon_q.push_back(ram_din);
        if (ram_rx_valid && ram_tx_valid) overlap_cnt++;
        if (!ram_rx_valid && ram_din != 10'h000) din_idle_bad++;
    end

    function automatic logic [29:0] exp_words(bit we, logic [7:0] a, logic [7:0] d);
        logic [1:0] op;
        op = we ? 2'b00 : 2'b10;
        return {op, a, op, a, (we ? {2'b01, d} : {2'b11, 8'h00})};
    endfunction

    function automatic logic [29:0] obs_words();
        if (mon_q.size() != 3) return 'x;
        return {mon_q[0], mon_q[1], mon_q[2]};
    endfunction

    // One transaction on one port; lat counts cycles from the grant cycle (0) to ack.
    task automatic txn(input bit port, input bit we, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output logic [7:0] rd, output logic er, output logic stray);
        @(negedge clk);
        mon_q.delete();
        lat = -1; rd = 'x; er = 1'bx; stray = 1'b0;
        if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (port ? ack0 : ack1) stray = 1'b1;
            if (port ? ack1 : ack0) begin lat = c; rd = rdata; er = err; break; end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        if (ack0 || ack1) stray = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({ack0, ack1, rdata, err, busy, ram_din, ram_rx_valid} !== 23'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, expected 0", {ack0, ack1, rdata, err, busy, ram_din, ram_rx_valid});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin
            tests_failed++; $display("FAIL reset_idle: busy=%b state=%0d, expected busy=0 IDLE", busy, state_dbg);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [7:0] rd; logic er, st;
        txn(1'b1, 1'b1, 8'h3C, 8'hA5, lat, rd, er, st);
        ref_mem[8'h3C] = 8'hA5;
        tests_run++;
        if (lat !== 4) begin tests_failed++; $display("FAIL wr_latency: got %0d, expected 4", lat); end
        tests_run++;
        if (obs_words() !== exp_words(1'b1, 8'h3C, 8'hA5)) begin
            tests_failed++; $display("FAIL wr_words: got %h, expected %h", obs_words(), exp_words(1'b1, 8'h3C, 8'hA5));
        end
        tests_run++;
        if ({er, st} !== 2'b00) begin tests_failed++; $display("FAIL wr_err_stray: got %b, expected 00", {er, st}); end
        txn(1'b1, 1'b0, 8'h3C, 8'h00, lat, rd, er, st);
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL rd_latency: got %0d, expected 5", lat); end
        tests_run++;
        if (obs_words() !== exp_words(1'b0, 8'h3C, 8'h00)) begin
            tests_failed++; $display("FAIL rd_words: got %h, expected %h", obs_words(), exp_words(1'b0, 8'h3C, 8'h00));
        end
        tests_run++;
        if ({rd, er, st} !== {ref_mem[8'h3C], 2'b00}) begin
            tests_failed++; $display("FAIL rd_data: got %h/%b/%b, expected %h/0/0", rd, er, st, ref_mem[8'h3C]);
        end
    endtask

    task automatic test_round_robin();
        int order[$]; int done0 = 0, done1 = 0, rr0 = 0, rr1 = 0;
        int lat; logic [7:0] rd; logic er, st;
        @(negedge clk);
        we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'h11; req0 = 1'b1;
        we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h22; req1 = 1'b1;
        for (int c = 0; c < 200 && order.size() < 4; c++) begin
            @(negedge clk);
            if (ack0) begin order.push_back(0); req0 = 1'b0; done0++; rr0 = (done0 < 2) ? 2 : 0; end
            else if (rr0 > 0) begin rr0--; if (rr0 == 0) req0 = 1'b1; end
            if (ack1) begin order.push_back(1); req1 = 1'b0; done1++; rr1 = (done1 < 2) ? 2 : 0; end
            else if (rr1 > 0) begin rr1--; if (rr1 == 0) req1 = 1'b1; end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        ref_mem[8'h10] = 8'h11; ref_mem[8'h20] = 8'h22;
        tests_run++;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
            tests_failed++; $display("FAIL rr_order: got %p, expected 0,1,0,1", order);
        end
        txn(1'b0, 1'b0, 8'h10, 8'h00, lat, rd, er, st);
        tests_run++;
        if (rd !== ref_mem[8'h10]) begin tests_failed++; $display("FAIL rr_readback0: got %h, expected %h", rd, ref_mem[8'h10]); end
        txn(1'b1, 1'b0, 8'h20, 8'h00, lat, rd, er, st);
        tests_run++;
        if (rd !== ref_mem[8'h20]) begin tests_failed++; $display("FAIL rr_readback1: got %h, expected %h", rd, ref_mem[8'h20]); end
    endtask

    task automatic test_tx_gating();
        int lat, exp_lat; logic [7:0] rd; logic er, st;
        txn(1'b0, 1'b1, 8'h33, 8'h77, lat, rd, er, st);
        ref_mem[8'h33] = 8'h77;
        tx_window = 8;
        txn(1'b0, 1'b0, 8'h33, 8'h00, lat, rd, er, st);
        tests_run++;
        if ({lat, rd} !== {32'd5, ref_mem[8'h33]}) begin
            tests_failed++; $display("FAIL gate_read: got lat %0d data %h, expected 5 %h", lat, rd, ref_mem[8'h33]);
        end
        // Read's tx window covers its cycles 4..3+W; the write is raised in read cycle 7.
        exp_lat = ((4 + tx_window > 7) ? (4 + tx_window - 7) : 0) + 4;
        txn(1'b1, 1'b1, 8'h33, 8'h99, lat, rd, er, st);
        ref_mem[8'h33] = 8'h99;
        tx_window = 3;
        tests_run++;
        if (lat !== exp_lat) begin tests_failed++; $display("FAIL gate_wr_latency: got %0d, expected %0d", lat, exp_lat); end
        txn(1'b1, 1'b0, 8'h33, 8'h00, lat, rd, er, st);
        tests_run++;
        if (rd !== ref_mem[8'h33]) begin tests_failed++; $display("FAIL gate_readback: got %h, expected %h", rd, ref_mem[8'h33]); end
    endtask

    task automatic test_timeout();
        int lat; logic [7:0] rd; logic er, st;
        stub_mode = 1'b1;
        txn(1'b0, 1'b0, 8'h05, 8'h00, lat, rd, er, st);
        stub_mode = 1'b0;
        tests_run++;
        if (lat !== 4 + TIMEOUT) begin tests_failed++; $display("FAIL to_latency: got %0d, expected %0d", lat, 4 + TIMEOUT); end
        tests_run++;
        if ({rd, er, st} !== {8'h00, 2'b10}) begin
            tests_failed++; $display("FAIL to_result: got rdata %h err %b stray %b, expected 00 1 0", rd, er, st);
        end
        tests_run++;
        if (obs_words() !== exp_words(1'b0, 8'h05, 8'h00)) begin
            tests_failed++; $display("FAIL to_words: got %h, expected %h", obs_words(), exp_words(1'b0, 8'h05, 8'h00));
        end
        tests_run++;
        if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin
            tests_failed++; $display("FAIL to_idle: busy=%b state=%0d, expected 0 IDLE", busy, state_dbg);
        end
    endtask

    task automatic test_reset_midtxn();
        int lat; logic [7:0] rd; logic er, st; bit seen = 1'b0;
        @(negedge clk);
        we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'hEE; req0 = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (state_dbg !== ST_ADDR1) begin tests_failed++; $display("FAIL mid_state: got %0d, expected %0d", state_dbg, ST_ADDR1); end
        reset_n = 1'b0; req0 = 1'b0;
        #1;
        tests_run++;
        if ({ack0, ack1, rdata, err, busy, ram_din, ram_rx_valid} !== 23'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got %h, expected 0", {ack0, ack1, rdata, err, busy, ram_din, ram_rx_valid});
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) begin @(negedge clk); if (ack0 || ack1) seen = 1'b1; end
        tests_run++;
        if (seen) begin tests_failed++; $display("FAIL mid_no_ack: got ack after reset, expected none"); end
        txn(1'b0, 1'b1, 8'h40, 8'h3B, lat, rd, er, st);
        ref_mem[8'h40] = 8'h3B;
        txn(1'b0, 1'b0, 8'h40, 8'h00, lat, rd, er, st);
        tests_run++;
        if ({lat, rd} !== {32'd5, ref_mem[8'h40]}) begin
            tests_failed++; $display("FAIL mid_readback: got lat %0d data %h, expected 5 %h", lat, rd, ref_mem[8'h40]);
        end
    endtask

    task automatic test_addr_boundary();
        int lat; logic [7:0] rd; logic er, st;
        txn(1'b0, 1'b1, 8'hFF, 8'h5A, lat, rd, er, st);
        ref_mem[8'hFF] = 8'h5A;
        tests_run++;
        if (obs_words() !== exp_words(1'b1, 8'hFF, 8'h5A)) begin
            tests_failed++; $display("FAIL ff_words: got %h, expected %h", obs_words(), exp_words(1'b1, 8'hFF, 8'h5A));
        end
        txn(1'b1, 1'b1, 8'h00, 8'hC3, lat, rd, er, st);
        ref_mem[8'h00] = 8'hC3;
        txn(1'b1, 1'b0, 8'hFF, 8'h00, lat, rd, er, st);
        tests_run++;
        if (rd !== ref_mem[8'hFF]) begin tests_failed++; $display("FAIL ff_readback: got %h, expected %h", rd, ref_mem[8'hFF]); end
        txn(1'b0, 1'b0, 8'h00, 8'h00, lat, rd, er, st);
        tests_run++;
        if (rd !== ref_mem[8'h00]) begin tests_failed++; $display("FAIL zero_readback: got %h, expected %h", rd, ref_mem[8'h00]); end
    endtask

    task automatic test_random();
        logic [7:0] written[$];
        int lat; logic [7:0] rd, a, d; logic er, st; bit port, we;
        for (int i = 0; i < 24; i++) begin
            port = 1'($urandom_range(0, 1));
            we   = (written.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            a    = we ? 8'($urandom_range(0, 255)) : written[$urandom_range(0, written.size() - 1)];
            d    = 8'($urandom_range(0, 255));
            if (!we) exp_q.push_back(ref_mem[a]);
            txn(port, we, a, d, lat, rd, er, st);
            if (we) begin ref_mem[a] = d; written.push_back(a); end
            tests_run++;
            if (lat !== (we ? 4 : 5)) begin tests_failed++; $display("FAIL rnd_latency[%0d]: got %0d, expected %0d", i, lat, we ? 4 : 5); end
            tests_run++;
            if (obs_words() !== exp_words(we, a, d)) begin
                tests_failed++; $display("FAIL rnd_words[%0d]: got %h, expected %h", i, obs_words(), exp_words(we, a, d));
            end
            tests_run++;
            if ({er, st} !== 2'b00) begin tests_failed++; $display("FAIL rnd_err_stray[%0d]: got %b, expected 00", i, {er, st}); end
            if (!we) begin
                tests_run++;
                if (rd !== exp_q[0]) begin tests_failed++; $display("FAIL rnd_rdata[%0d]: got %h, expected %h", i, rd, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_protocol();
        tests_run++;
        if (overlap_cnt !== 0) begin tests_failed++; $display("FAIL rx_during_tx: got %0d words, expected 0", overlap_cnt); end
        tests_run++;
        if (din_idle_bad !== 0) begin tests_failed++; $display("FAIL din_idle_nonzero: got %0d cycles, expected 0", din_idle_bad); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_tx_gating();
        test_timeout();
        test_reset_midtxn();
        test_addr_boundary();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
